// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard unit: operand forwarding, load-use and mul/div stalls
//
// Purpose: selects forwarding sources for the decode-stage operands, detects
// load-use hazards, and tracks one outstanding multiply/divide result so that
// dependent or structurally conflicting instructions are held in decode.
// Optional macro HAZARD_PERF_EN adds saturating stall performance counters.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   rs, rt               decode-stage source registers
//   rs_used, rt_used     decode instruction actually reads rs / rt
//   src_dst, src_rw      packed destination and write enable per forwarding source
//                        (0=EX, 1=MEM, 2=WB, 3=extra stage)
//   ex_load              instruction in EX is a load
//   md_issue, md_dst     mul/div issuing from decode and its destination
//   ctrl_rs, ctrl_rt     operand select: 0=regfile, i+1=forwarding source i
//   stall                hold decode/fetch, bubble into EX
//   md_busy              mul/div result outstanding
//   stall_cycles         (HAZARD_PERF_EN) cycles with stall asserted
//   md_stall_cycles      (HAZARD_PERF_EN) cycles stalled by the mul/div scoreboard
module hazard_unit #(
  parameter int NSRC   = 3,
  parameter int REGW   = 5,
  parameter int MD_LAT = 4,
  localparam int SELW  = $clog2(NSRC + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [REGW-1:0]      rs,
  input  logic [REGW-1:0]      rt,
  input  logic                 rs_used,
  input  logic                 rt_used,
  input  logic [NSRC*REGW-1:0] src_dst,
  input  logic [NSRC-1:0]      src_rw,
  input  logic                 ex_load,
  input  logic                 md_issue,
  input  logic [REGW-1:0]      md_dst,
  output logic [SELW-1:0]      ctrl_rs,
  output logic [SELW-1:0]      ctrl_rt,
  output logic                 stall,
  output logic                 md_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          md_stall_cycles
`endif
);

  logic [3:0]      md_cnt_q, md_cnt_d;
  logic [REGW-1:0] md_reg_q, md_reg_d;
  logic [REGW-1:0] ex_dst;
  logic            load_use;
  logic            md_raw;
  logic            md_struct;
  logic            md_stall;
  logic            md_accept;

  // Walk from the oldest source down to EX so the youngest matching producer
  // (lowest index) is the one left in the select.
  always_comb begin
    ctrl_rs = '0;
    ctrl_rt = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_rw[i] && (src_dst[i*REGW +: REGW] != '0)) begin
        if (src_dst[i*REGW +: REGW] == rs) ctrl_rs = SELW'(i + 1);
        if (src_dst[i*REGW +: REGW] == rt) ctrl_rt = SELW'(i + 1);
      end
    end
  end

  assign ex_dst   = src_dst[REGW-1:0];
  assign load_use = ex_load && src_rw[0] && (ex_dst != '0) &&
                    ((rs_used && (ex_dst == rs)) || (rt_used && (ex_dst == rt)));

  assign md_busy   = (md_cnt_q != '0);
  assign md_raw    = md_busy && (md_reg_q != '0) &&
                     ((rs_used && (md_reg_q == rs)) || (rt_used && (md_reg_q == rt)));
  // A single result slot: a new mul/div waits until the previous one drains.
  assign md_struct = md_issue && md_busy;
  assign md_stall  = md_raw || md_struct;
  assign stall     = load_use || md_stall;
  assign md_accept = md_issue && !stall;

  always_comb begin
    md_cnt_d = md_cnt_q;
    md_reg_d = md_reg_q;
    if (md_accept) begin
      md_cnt_d = 4'(MD_LAT);
      md_reg_d = md_dst;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt_q <= '0;
      md_reg_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
      md_reg_q <= md_reg_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    md_stall_cnt_d = md_stall_cnt_q;
    if (stall && (stall_cnt_q != '1))       stall_cnt_d    = stall_cnt_q + 32'd1;
    if (md_stall && (md_stall_cnt_q != '1)) md_stall_cnt_d = md_stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      md_stall_cnt_q <= md_stall_cnt_d;
    end
  end

  assign stall_cycles    = stall_cnt_q;
  assign md_stall_cycles = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed vector bench for hazard_unit (NSRC=3, REGW=5, MD_LAT=4)
module tb_hazard_unit;

  localparam int NSRC = 3;
  localparam int REGW = 5;
  localparam int SELW = 2;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [REGW-1:0]      rs, rt, md_dst;
  logic                 rs_used, rt_used, ex_load, md_issue;
  logic [NSRC*REGW-1:0] src_dst;
  logic [NSRC-1:0]      src_rw;
  logic [SELW-1:0]      ctrl_rs, ctrl_rt;
  logic                 stall, md_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0]          stall_cycles, md_stall_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_unit #(.NSRC(NSRC), .REGW(REGW), .MD_LAT(4)) dut (
    .clk(clk), .reset_n(reset_n), .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used),
    .src_dst(src_dst), .src_rw(src_rw), .ex_load(ex_load), .md_issue(md_issue),
    .md_dst(md_dst), .ctrl_rs(ctrl_rs), .ctrl_rt(ctrl_rt), .stall(stall), .md_busy(md_busy)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .md_stall_cycles(md_stall_cycles)
`endif
  );

  typedef struct {
    string           name;
    logic [REGW-1:0] rs, rt;
    logic            rs_used, rt_used;
    logic [14:0]     src_dst;   // {WB, MEM, EX}
    logic [2:0]      src_rw;
    logic            ex_load;
    int              exp_rs, exp_rt, exp_stall;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rs = '0; rt = '0; rs_used = 1'b0; rt_used = 1'b0;
    src_dst = '0; src_rw = '0; ex_load = 1'b0; md_issue = 1'b0; md_dst = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{"mem_wins",     5, 0, 1, 0, {5'd5, 5'd5, 5'd7}, 3'b111, 0, 2, 0, 0};
    vecs[1]  = '{"ex_wins",      5, 0, 1, 0, {5'd5, 5'd5, 5'd5}, 3'b111, 0, 1, 0, 0};
    vecs[2]  = '{"reg0",         0, 0, 1, 1, {5'd0, 5'd0, 5'd0}, 3'b111, 0, 0, 0, 0};
    vecs[3]  = '{"mem_wb",       3, 4, 1, 1, {5'd4, 5'd3, 5'd0}, 3'b111, 0, 2, 3, 0};
    vecs[4]  = '{"wb_rw_off",    3, 4, 1, 1, {5'd4, 5'd3, 5'd0}, 3'b011, 0, 2, 0, 0};
    vecs[5]  = '{"loaduse_rt",   1, 9, 1, 1, {5'd0, 5'd0, 5'd9}, 3'b001, 1, 0, 1, 1};
    vecs[6]  = '{"loaduse_nort", 1, 9, 1, 0, {5'd0, 5'd0, 5'd9}, 3'b001, 1, 0, 1, 0};
    vecs[7]  = '{"load_norw",    1, 9, 1, 1, {5'd0, 5'd0, 5'd9}, 3'b000, 1, 0, 0, 0};
    vecs[8]  = '{"load_reg0",    0, 0, 1, 1, {5'd0, 5'd0, 5'd0}, 3'b001, 1, 0, 0, 0};
    vecs[9]  = '{"loaduse_rs",   9, 2, 1, 1, {5'd0, 5'd0, 5'd9}, 3'b001, 1, 1, 0, 1};
    vecs[10] = '{"both_wb",      6, 6, 0, 0, {5'd6, 5'd0, 5'd0}, 3'b100, 0, 3, 3, 0};

    idle();
    reset_n = 1'b0;
    #1;
    chk("rst_busy", md_busy, 0);
    chk("rst_stall", stall, 0);
    // forwarding stays live while reset is held
    rs = 5'd7; src_dst = {5'd0, 5'd0, 5'd7}; src_rw = 3'b001;
    #1;
    chk("rst_fwd", ctrl_rs, 1);
    idle();
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rs = vecs[i].rs; rt = vecs[i].rt; rs_used = vecs[i].rs_used; rt_used = vecs[i].rt_used;
      src_dst = vecs[i].src_dst; src_rw = vecs[i].src_rw; ex_load = vecs[i].ex_load;
      #1;
      chk({vecs[i].name, ".ctrl_rs"}, ctrl_rs, vecs[i].exp_rs);
      chk({vecs[i].name, ".ctrl_rt"}, ctrl_rt, vecs[i].exp_rt);
      chk({vecs[i].name, ".stall"}, stall, vecs[i].exp_stall);
    end
    idle();
    do_reset();

    // mul/div RAW: busy for 4 cycles, dependent read stalls exactly those 4
    @(negedge clk);
    md_issue = 1'b1; md_dst = 5'd12;
    #1;
    chk("md_issue_stall", stall, 0);
    chk("md_issue_busy", md_busy, 0);
    @(negedge clk);
    md_issue = 1'b0; rs = 5'd12; rs_used = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("md_raw_busy%0d", k), md_busy, 1);
      chk($sformatf("md_raw_stall%0d", k), stall, 1);
      @(negedge clk);
    end
    #1;
    chk("md_raw_busy_end", md_busy, 0);
    chk("md_raw_stall_end", stall, 0);
    idle();

    // second issue two cycles after the first waits for the drain
    @(negedge clk);
    md_issue = 1'b1; md_dst = 5'd12;
    @(negedge clk);
    md_issue = 1'b0;
    @(negedge clk);
    md_issue = 1'b1; md_dst = 5'd13;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("md_struct_stall%0d", k), stall, 1);
      @(negedge clk);
    end
    #1;
    chk("md_struct_accept", stall, 0);
    chk("md_struct_busy0", md_busy, 0);
    @(negedge clk);
    md_issue = 1'b0; rs = 5'd13; rs_used = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("md_second_stall%0d", k), stall, 1);
      @(negedge clk);
    end
    #1;
    chk("md_second_clear", stall, 0);

    // reset mid-operation abandons the result
    idle();
    @(negedge clk);
    md_issue = 1'b1; md_dst = 5'd13;
    @(negedge clk);
    md_issue = 1'b0; rs = 5'd13; rs_used = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_busy", md_busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", md_busy, 0);
    chk("mid_rst_stall", stall, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_stall", stall, 0);

    // destination r0 never creates a RAW stall
    idle();
    @(negedge clk);
    md_issue = 1'b1; md_dst = 5'd0;
    @(negedge clk);
    md_issue = 1'b0; rs_used = 1'b1; rt_used = 1'b1;
    #1;
    chk("md_r0_busy", md_busy, 1);
    chk("md_r0_stall", stall, 0);
    idle();

`ifdef HAZARD_PERF_EN
    do_reset();
    #1;
    chk("perf_rst", stall_cycles, 0);
    @(negedge clk);
    ex_load = 1'b1; src_dst = {5'd0, 5'd0, 5'd9}; src_rw = 3'b001; rt = 5'd9; rt_used = 1'b1;
    repeat (3) @(negedge clk);
    idle();
    md_issue = 1'b1; md_dst = 5'd12;
    @(negedge clk);
    md_issue = 1'b0; rs = 5'd12; rs_used = 1'b1;
    repeat (4) @(negedge clk);
    idle();
    #1;
    chk("perf_stall_cycles", stall_cycles, 7);
    chk("perf_md_stall_cycles", md_stall_cycles, 4);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    force dut.md_stall_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.stall_cnt_q;
    release dut.md_stall_cnt_q;
    md_issue = 1'b1; md_dst = 5'd14;
    @(negedge clk);
    md_issue = 1'b0; rs = 5'd14; rs_used = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("perf_sat_stall", stall_cycles, 32'hFFFF_FFFF);
    chk("perf_sat_md", md_stall_cycles, 32'hFFFF_FFFF);
    idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
